hold_dma: RTL and testbench
===========================

HOLD_DMA -- requirements
Module: hold_dma

Interface
REQ-001 Parameter: wide, 32, data and address width of all bus and register ports.
REQ-002 Parameter: base, 5'b11000, register-select base; registers at base+0 SRC, base+1 DST, base+2 LEN, base+3 CTRL.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 we  input  1  CPU register write strobe.
REQ-006 addr  input  5  CPU register select.
REQ-007 wd  input  wide  CPU write data.
REQ-008 rd  output  wide  CPU readback of the register selected by addr (combinational); CTRL reads as {29'b0, err, done, busy}.
REQ-009 hold  output  1  bus request to the main decoder.
REQ-010 holdACK  input  1  bus grant from the main decoder.
REQ-011 mem_we  output  1  data-memory write enable while the bus is owned.
REQ-012 mem_a  output  wide  data-memory byte address.
REQ-013 mem_d  output  wide  data-memory write data.
REQ-014 mem_q  input  wide  data-memory read data (combinational read of mem_a).
REQ-015 busy  output  1  transfer in progress.
REQ-016 irq  output  1  level interrupt; equals done.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, RD, WR and FIN.
REQ-018 In IDLE, writing SRC, DST or LEN SHALL load wd on that clock edge.
REQ-019 In IDLE, writing CTRL with wd[0]=1 SHALL clear done and err, copy SRC, DST and LEN into working counters, and enter REQ (or FIN if LEN=0).
REQ-020 In IDLE, writing CTRL with wd[0]=0 SHALL only clear done and err.
REQ-021 In REQ the block SHALL assert hold and SHALL move to RD on the first edge where holdACK=1.
REQ-022 In RD the block SHALL drive mem_a=working src; on an edge with holdACK=1 it SHALL latch mem_q into a data register and move to WR.
REQ-023 In WR the block SHALL drive mem_a=working dst, mem_d=data register and mem_we=holdACK; on an edge with holdACK=1 it SHALL add 4 to src and dst, decrement count, and go to RD (count>1) or FIN (count=1).
REQ-024 If holdACK=0 in RD or WR, the block SHALL stall with no state, counter or memory change and mem_we=0, keeping hold=1.
REQ-025 hold SHALL be 1 in REQ, RD and WR, and 0 in IDLE and FIN.
REQ-026 FIN SHALL last one cycle, set done=1, and return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Address arithmetic SHALL be modulo 2^wide, so 32'hFFFF_FFFC+4 wraps to 0.
REQ-029 While busy=1, any CPU write SHALL be ignored and SHALL set err=1.
REQ-030 mem_a SHALL be 0 and mem_we SHALL be 0 whenever the state is not RD or WR.
REQ-031 rd SHALL return 0 for addr outside base..base+3.

Reset
REQ-032 Asserting rst SHALL immediately force IDLE; SRC, DST, LEN, counters, data register, done and err go to 0.
REQ-033 During reset, hold, mem_we, busy and irq SHALL be 0, including reset asserted in mid-transfer.
REQ-034 Memory writes in progress at reset SHALL be abandoned, with no further mem_we pulse.

Verification
REQ-035 Scenario: SRC=0x100, DST=0x200, LEN=3, CTRL=1, holdACK tied 1 -> hold rises the next cycle; three mem_we pulses to 0x200, 0x204, 0x208 carrying words from 0x100..0x108; irq=1 after 8 cycles; hold=0.
REQ-036 Scenario: LEN=0, CTRL=1 -> hold never asserts; done=1 one cycle later; no mem_we.
REQ-037 Scenario: holdACK held 0 for 5 cycles after start, then toggled 0 for 2 cycles during WR -> hold stays 1; no mem_we while holdACK=0; final memory contents are correct.
REQ-038 Scenario: write LEN while busy -> LEN unchanged; err=1; CTRL read = 3'b101 mid-transfer.
REQ-039 Scenario: SRC=0xFFFFFFFC, LEN=2 -> second read address is 0x0.
REQ-040 Scenario: rst pulsed during WR -> hold, mem_we and busy drop asynchronously; irq=0; all registers read 0.

Source files
------------

// File: rtl/hold_dma.sv
// Single-channel word-copy DMA that borrows the data bus from the main decoder
// via a hold/holdACK handshake and copies LEN words from SRC to DST.
module hold_dma #(
  parameter int          wide = 32,
  parameter logic [4:0]  base = 5'b11000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [wide-1:0] wd,
  output logic [wide-1:0] rd,
  output logic            hold,
  input  logic            holdACK,
  output logic            mem_we,
  output logic [wide-1:0] mem_a,
  output logic [wide-1:0] mem_d,
  input  logic [wide-1:0] mem_q,
  output logic            busy,
  output logic            irq
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, FIN} state_t;

  localparam logic [4:0]      AddrSrc  = base;
  localparam logic [4:0]      AddrDst  = base + 5'd1;
  localparam logic [4:0]      AddrLen  = base + 5'd2;
  localparam logic [4:0]      AddrCtrl = base + 5'd3;
  localparam logic [wide-1:0] WordStep = wide'(4);
  localparam logic [wide-1:0] OneWord  = wide'(1);

  state_t          state_q, state_d;
  logic [wide-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [wide-1:0] workSrc_q, workSrc_d, workDst_q, workDst_d;
  logic [wide-1:0] count_q, count_d, data_q, data_d;
  logic            done_q, done_d, err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      workSrc_q <= '0;
      workDst_q <= '0;
      count_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      workSrc_q <= workSrc_d;
      workDst_q <= workDst_d;
      count_q   <= count_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    workSrc_d = workSrc_q;
    workDst_d = workDst_q;
    count_d   = count_q;
    data_d    = data_q;
    done_d    = done_q;
    err_d     = err_q;
    hold      = 1'b0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_d     = '0;
    busy      = (state_q != IDLE);
    irq       = done_q;

    // The register file is only writable while idle; any write attempt during a transfer is flagged.
    if (busy && we) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (we) begin
          case (addr)
            AddrSrc: src_d = wd;
            AddrDst: dst_d = wd;
            AddrLen: len_d = wd;
            AddrCtrl: begin
              done_d = 1'b0;
              err_d  = 1'b0;
              if (wd[0]) begin
                workSrc_d = src_q;
                workDst_d = dst_q;
                count_d   = len_q;
                state_d   = (len_q == '0) ? FIN : REQ;
              end
            end
            default: ;
          endcase
        end
      end
      REQ: begin
        hold = 1'b1;
        if (holdACK) state_d = RD;
      end
      RD: begin
        hold  = 1'b1;
        mem_a = workSrc_q;
        if (holdACK) begin
          data_d  = mem_q;
          state_d = WR;
        end
      end
      WR: begin
        hold   = 1'b1;
        mem_a  = workDst_q;
        mem_d  = data_q;
        mem_we = holdACK;
        if (holdACK) begin
          workSrc_d = workSrc_q + WordStep;
          workDst_d = workDst_q + WordStep;
          count_d   = count_q - OneWord;
          state_d   = (count_q == OneWord) ? FIN : RD;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (addr)
      AddrSrc:  rd = src_q;
      AddrDst:  rd = dst_q;
      AddrLen:  rd = len_q;
      AddrCtrl: rd = {{(wide-3){1'b0}}, err_q, done_q, busy};
      default:  rd = '0;
    endcase
  end

endmodule

// File: tb/tb_hold_dma.sv
// Directed bench for hold_dma: a word-level transfer model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_hold_dma;

  localparam logic [4:0] SRC  = 5'd24;
  localparam logic [4:0] DST  = 5'd25;
  localparam logic [4:0] LEN  = 5'd26;
  localparam logic [4:0] CTRL = 5'd27;

  logic        clk = 1'b0;
  logic        rst, we, holdACK;
  logic [4:0]  addr;
  logic [31:0] wd, rd, mem_a, mem_d, mem_q;
  logic        hold, mem_we, busy, irq;

  int checks = 0;
  int errors = 0;

  // Bus-side memory: untouched words read back as C0DE_0000 | word index.
  logic [31:0] mem [1024];
  bit          memValid [1024];
  logic [31:0] wrLog [$];

  // Transfer model state, described in terms of words moved rather than FSM states.
  logic [31:0] gold [1024];
  logic [31:0] mSrc, mDst, mLen, mSrcW, mDstW, mData, kOff;
  bit          mDone, mErr, mBusy, mFin, mGranted;
  int          mStep, mLenW;
  logic [31:0] expRd, expA;
  bit          expHold, expWe, busPhase;

  always #5 clk = ~clk;

  assign mem_q = memValid[mem_a[11:2]] ? mem[mem_a[11:2]] : (32'hC0DE_0000 | {22'b0, mem_a[11:2]});

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[11:2]]      <= mem_d;
      memValid[mem_a[11:2]] <= 1'b1;
      wrLog.push_back(mem_a);
    end
  end

  hold_dma #(.wide(32), .base(5'b11000)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .hold(hold), .holdACK(holdACK), .mem_we(mem_we), .mem_a(mem_a),
    .mem_d(mem_d), .mem_q(mem_q), .busy(busy), .irq(irq)
  );

  function automatic logic [31:0] memRead(logic [31:0] a);
    return memValid[a[11:2]] ? mem[a[11:2]] : (32'hC0DE_0000 | {22'b0, a[11:2]});
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    mSrc = '0; mDst = '0; mLen = '0; mSrcW = '0; mDstW = '0; mData = '0;
    mDone = 0; mErr = 0; mBusy = 0; mFin = 0; mGranted = 0; mStep = 0; mLenW = 0;
  endtask

  task automatic computeExpect();
    busPhase = mBusy && !mFin && mGranted;
    kOff     = 32'(mStep / 2) << 2;
    expHold  = mBusy && !mFin;
    expA     = !busPhase ? 32'h0 : ((mStep % 2 == 0) ? mSrcW + kOff : mDstW + kOff);
    expWe    = busPhase && (mStep % 2 == 1) && holdACK;
    case (addr)
      SRC:     expRd = mSrc;
      DST:     expRd = mDst;
      LEN:     expRd = mLen;
      CTRL:    expRd = {29'b0, mErr, mDone, mBusy};
      default: expRd = 32'h0;
    endcase
  endtask

  task automatic stepModel();
    kOff = 32'(mStep / 2) << 2;
    if (mBusy) begin
      if (we) mErr = 1;
      if (mFin) begin
        mFin = 0; mBusy = 0; mDone = 1;
      end else if (!mGranted) begin
        if (holdACK) mGranted = 1;
      end else if (holdACK) begin
        if (mStep % 2 == 0) mData = gold[(mSrcW + kOff) >> 2 & 32'h3FF];
        else begin
          gold[(mDstW + kOff) >> 2 & 32'h3FF] = mData;
          if (mStep + 1 == 2 * mLenW) begin
            mFin = 1; mGranted = 0;
          end
        end
        mStep++;
      end
    end else if (we) begin
      case (addr)
        SRC: mSrc = wd;
        DST: mDst = wd;
        LEN: mLen = wd;
        CTRL: begin
          mDone = 0; mErr = 0;
          if (wd[0]) begin
            mBusy = 1; mGranted = 0; mStep = 0;
            mSrcW = mSrc; mDstW = mDst; mLenW = int'(mLen);
            mFin  = (mLen == 32'h0);
          end
        end
        default: ;
      endcase
    end
  endtask

  // Compare process: sample one time unit before each rising edge, then advance the model on the edge.
  initial begin : compareProc
    for (int i = 0; i < 1024; i++) gold[i] = 32'hC0DE_0000 | 32'(i);
    resetModel();
    forever begin
      @(negedge clk);
      #4;
      if (rst) resetModel();
      computeExpect();
      checkOutput("hold", {31'b0, hold}, {31'b0, expHold});
      checkOutput("busy", {31'b0, busy}, {31'b0, mBusy});
      checkOutput("irq", {31'b0, irq}, {31'b0, mDone});
      checkOutput("mem_we", {31'b0, mem_we}, {31'b0, expWe});
      checkOutput("mem_a", mem_a, expA);
      checkOutput("rd", rd, expRd);
      if (expWe) checkOutput("mem_d", mem_d, mData);
      @(posedge clk);
      if (rst) resetModel();
      else stepModel();
    end
  end

  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wd = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic checkRead(input string name, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    #1;
    checkOutput(name, rd, exp);
  endtask

  task automatic waitDone();
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    checkOutput("done timeout", {31'b0, busy}, 32'h0);
  endtask

  int logBase;

  initial begin : stimulus
    rst = 1'b1; we = 1'b0; addr = 5'd0; wd = '0; holdACK = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset hold", {31'b0, hold}, 32'h0);
    checkOutput("reset busy", {31'b0, busy}, 32'h0);
    checkOutput("reset mem_we", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    checkRead("reset ctrl", CTRL, 32'h0);
    checkRead("reset src", SRC, 32'h0);

    // Three-word copy with a permanently granted bus.
    holdACK = 1'b1;
    applyStimulus(SRC, 32'h100);
    applyStimulus(DST, 32'h200);
    applyStimulus(LEN, 32'd3);
    applyStimulus(CTRL, 32'd1);
    #1;
    checkOutput("s1 hold rises", {31'b0, hold}, 32'h1);
    repeat (7) @(negedge clk);
    #1;
    checkOutput("s1 irq before 8", {31'b0, irq}, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("s1 irq after 8", {31'b0, irq}, 32'h1);
    checkOutput("s1 hold off", {31'b0, hold}, 32'h0);
    checkOutput("s1 write count", 32'(wrLog.size()), 32'd3);
    if (wrLog.size() == 3) begin
      checkOutput("s1 addr0", wrLog[0], 32'h200);
      checkOutput("s1 addr1", wrLog[1], 32'h204);
      checkOutput("s1 addr2", wrLog[2], 32'h208);
    end
    checkOutput("s1 data0", memRead(32'h200), 32'hC0DE_0040);
    checkOutput("s1 data1", memRead(32'h204), 32'hC0DE_0041);
    checkOutput("s1 data2", memRead(32'h208), 32'hC0DE_0042);

    // Zero-length transfer goes straight to completion.
    applyStimulus(LEN, 32'd0);
    applyStimulus(CTRL, 32'd1);
    #1;
    checkOutput("s2 hold", {31'b0, hold}, 32'h0);
    checkOutput("s2 busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    #1;
    checkOutput("s2 irq", {31'b0, irq}, 32'h1);
    checkOutput("s2 no writes", 32'(wrLog.size()), 32'd3);

    // Grant withheld for five cycles, then dropped twice while a write is pending.
    holdACK = 1'b0;
    applyStimulus(SRC, 32'h300);
    applyStimulus(DST, 32'h400);
    applyStimulus(LEN, 32'd2);
    applyStimulus(CTRL, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput("s3 hold waiting", {31'b0, hold}, 32'h1);
    end
    holdACK = 1'b1;
    repeat (2) @(negedge clk);
    holdACK = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("s3 stall mem_we", {31'b0, mem_we}, 32'h0);
      checkOutput("s3 stall hold", {31'b0, hold}, 32'h1);
      checkOutput("s3 stall mem_a", mem_a, 32'h400);
      @(negedge clk);
    end
    holdACK = 1'b1;
    waitDone();
    checkOutput("s3 data0", memRead(32'h400), 32'hC0DE_00C0);
    checkOutput("s3 data1", memRead(32'h404), 32'hC0DE_00C1);
    checkOutput("s3 write count", 32'(wrLog.size()), 32'd5);

    // Register writes during a transfer are rejected and flagged.
    holdACK = 1'b0;
    applyStimulus(DST, 32'h700);
    applyStimulus(CTRL, 32'd1);
    applyStimulus(LEN, 32'd7);
    checkRead("s4 ctrl busy", CTRL, 32'h5);
    checkRead("s4 len kept", LEN, 32'd2);
    holdACK = 1'b1;
    waitDone();
    checkRead("s4 ctrl done", CTRL, 32'h6);
    applyStimulus(CTRL, 32'd0);
    checkRead("s4 ctrl cleared", CTRL, 32'h0);

    // Source address wraps past the top of the address space.
    applyStimulus(SRC, 32'hFFFF_FFFC);
    applyStimulus(DST, 32'h500);
    applyStimulus(CTRL, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("s5 first read", mem_a, 32'hFFFF_FFFC);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("s5 wrapped read", mem_a, 32'h0);
    waitDone();
    checkOutput("s5 data0", memRead(32'h500), 32'hC0DE_03FF);
    checkOutput("s5 data1", memRead(32'h504), 32'hC0DE_0000);

    // Reset in the middle of a write beat.
    applyStimulus(SRC, 32'h100);
    applyStimulus(DST, 32'h600);
    applyStimulus(LEN, 32'd3);
    logBase = wrLog.size();
    applyStimulus(CTRL, 32'd1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("s6 writing", {31'b0, mem_we}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("s6 rst hold", {31'b0, hold}, 32'h0);
    checkOutput("s6 rst mem_we", {31'b0, mem_we}, 32'h0);
    checkOutput("s6 rst busy", {31'b0, busy}, 32'h0);
    checkOutput("s6 rst irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("s6 no write", 32'(wrLog.size()), 32'(logBase));
    checkOutput("s6 dst untouched", memRead(32'h600), 32'hC0DE_0180);
    checkRead("s6 src", SRC, 32'h0);
    checkRead("s6 dst", DST, 32'h0);
    checkRead("s6 len", LEN, 32'h0);
    checkRead("s6 ctrl", CTRL, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("s6 idle after reset", {31'b0, hold}, 32'h0);

    for (int i = 0; i < 1024; i++)
      checkOutput("memory image", memRead(32'(i) << 2), gold[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
